masked_array_memory: RTL and testbench

MASKED_ARRAY_MEMORY -- requirements
Module: masked_array_memory

---
 rtl/masked_array_memory.sv | 140 ++++++++++++++
 tb/tb_masked_array_memory.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_array_memory.sv
// ============================================================================
// Module   : masked_array_memory
// Summary  : Word memory with per-element write mask, zero-fill sweep after
//            reset, and selectable registered or combinational read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module masked_array_memory #(
  parameter int DEPTH          = 4,
  parameter int NUM_ELEMS      = 2,
  parameter int ELEM_WIDTH     = 6,
  parameter int SYNC_READ      = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int DW = NUM_ELEMS * ELEM_WIDTH
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [AW-1:0]        WADDR,
  input  logic [DW-1:0]        WDATA,
  input  logic [NUM_ELEMS-1:0] WMASK,
  input  logic                 WE,
  input  logic [AW-1:0]        RADDR,
  input  logic                 RE,
  output logic [DW-1:0]        RDATA,
  output logic                 RVALID,
  output logic                 READY
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            w_wr_en;
  logic            w_raddr_ok;
  logic [DW-1:0]   w_rword;

  assign w_wr_en    = ready_q && WE && (int'(WADDR) < DEPTH);
  assign w_raddr_ok = (int'(RADDR) < DEPTH);
  assign w_rword    = w_raddr_ok ? mem_q[RADDR] : '0;
  assign READY      = ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    // READY is registered so it stays low throughout reset even when RUN is the reset state.
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage has no reset; zeroing happens only through the sweep.
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        if (WMASK[i]) begin
          mem_q[WADDR][i*ELEM_WIDTH +: ELEM_WIDTH] <= WDATA[i*ELEM_WIDTH +: ELEM_WIDTH];
        end
      end
    end
  end

  if (SYNC_READ != 0) begin : g_sync_read
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic [DW-1:0] w_fwd;

    // Write-first: masked elements of a same-address write bypass the array.
    always_comb begin
      w_fwd = w_rword;
      if (w_wr_en && (WADDR == RADDR)) begin
        for (int i = 0; i < NUM_ELEMS; i++) begin
          if (WMASK[i]) begin
            w_fwd[i*ELEM_WIDTH +: ELEM_WIDTH] = WDATA[i*ELEM_WIDTH +: ELEM_WIDTH];
          end
        end
      end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (ready_q && RE) begin
        rdata_q  <= w_fwd;
        rvalid_q <= 1'b1;
      end else begin
        rvalid_q <= 1'b0;
      end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
  end else begin : g_comb_read
    logic [DW-1:0] rdata_q;

    // Remembers the last visible word so RDATA holds while not ready.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        rdata_q <= '0;
      end else if (ready_q) begin
        rdata_q <= w_rword;
      end
    end

    assign RDATA  = ready_q ? w_rword : rdata_q;
    assign RVALID = ready_q & RE;
  end

endmodule

`default_nettype wire

// File: tb/tb_masked_array_memory.sv
// ============================================================================
// Module   : tb_masked_array_memory
// Summary  : Four configurations of masked_array_memory driven by shared
//            directed and random stimulus, compared with a word-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_masked_array_memory;

  logic        clk;
  logic        rstn;
  logic        we, re;
  logic [1:0]  waddr, raddr, wmask;
  logic [11:0] wdata;

  logic [11:0] rd0, rd1, rd2, rd3;
  logic        rv0, rv1, rv2, rv3;
  logic        ry0, ry1, ry2, ry3;
  logic [11:0] o_rd [4];
  logic        o_rv [4];
  logic        o_ry [4];

  int P_DEPTH [4] = '{4, 3, 4, 4};
  int P_SYNC  [4] = '{1, 1, 0, 1};
  int P_CLR   [4] = '{1, 1, 1, 0};

  logic [11:0] m_mem [4][4];
  logic [1:0]  m_kn  [4][4];
  int          m_n   [4];
  logic [11:0] m_rd  [4];
  logic        m_rv  [4];
  logic        m_rdk [4];

  int vectors;
  int errs;

  masked_array_memory #(.DEPTH(4)) u_d0 (
    .CLK(clk), .ASYNCRESETN(rstn), .WADDR(waddr), .WDATA(wdata), .WMASK(wmask),
    .WE(we), .RADDR(raddr), .RE(re), .RDATA(rd0), .RVALID(rv0), .READY(ry0));
  masked_array_memory #(.DEPTH(3)) u_d1 (
    .CLK(clk), .ASYNCRESETN(rstn), .WADDR(waddr), .WDATA(wdata), .WMASK(wmask),
    .WE(we), .RADDR(raddr), .RE(re), .RDATA(rd1), .RVALID(rv1), .READY(ry1));
  masked_array_memory #(.DEPTH(4), .SYNC_READ(0)) u_d2 (
    .CLK(clk), .ASYNCRESETN(rstn), .WADDR(waddr), .WDATA(wdata), .WMASK(wmask),
    .WE(we), .RADDR(raddr), .RE(re), .RDATA(rd2), .RVALID(rv2), .READY(ry2));
  masked_array_memory #(.DEPTH(4), .CLEAR_ON_RESET(0)) u_d3 (
    .CLK(clk), .ASYNCRESETN(rstn), .WADDR(waddr), .WDATA(wdata), .WMASK(wmask),
    .WE(we), .RADDR(raddr), .RE(re), .RDATA(rd3), .RVALID(rv3), .READY(ry3));

  assign o_rd[0] = rd0;
  assign o_rd[1] = rd1;
  assign o_rd[2] = rd2;
  assign o_rd[3] = rd3;
  assign o_rv[0] = rv0;
  assign o_rv[1] = rv1;
  assign o_rv[2] = rv2;
  assign o_rv[3] = rv3;
  assign o_ry[0] = ry0;
  assign o_ry[1] = ry1;
  assign o_ry[2] = ry2;
  assign o_ry[3] = ry3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit mready(int i);
    if (P_CLR[i] != 0) return m_n[i] >= P_DEPTH[i];
    return m_n[i] >= 1;
  endfunction

  task automatic chk(string tag, int i, logic [11:0] obs, logic [11:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
      end
  endtask

  task automatic set_in(logic w, logic [1:0] wa, logic [11:0] wd, logic [1:0] wm,
                        logic r, logic [1:0] ra);
    we = w; waddr = wa; wdata = wd; wmask = wm; re = r; raddr = ra;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_n[i]   = 0;
      m_rd[i]  = '0;
      m_rv[i]  = 1'b0;
      m_rdk[i] = 1'b1;
    end
  endtask

  // Reads see the array after this edge's write has been applied.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      bit r;
      int d;
      r = mready(i);
      d = P_DEPTH[i];
      if (P_SYNC[i] == 0 && r) begin
        if (int'(raddr) >= d) begin
          m_rd[i] = '0; m_rdk[i] = 1'b1;
        end else begin
          m_rd[i] = m_mem[i][raddr]; m_rdk[i] = (m_kn[i][raddr] == 2'b11);
        end
      end
      if (r && we && int'(waddr) < d) begin
        for (int e = 0; e < 2; e++) begin
          if (wmask[e]) begin
            m_mem[i][waddr][e*6 +: 6] = wdata[e*6 +: 6];
            m_kn[i][waddr][e] = 1'b1;
          end
        end
      end
      if (P_SYNC[i] != 0) begin
        if (r && re) begin
          m_rv[i] = 1'b1;
          if (int'(raddr) >= d) begin
            m_rd[i] = '0; m_rdk[i] = 1'b1;
          end else begin
            m_rd[i] = m_mem[i][raddr]; m_rdk[i] = (m_kn[i][raddr] == 2'b11);
          end
        end else begin
          m_rv[i] = 1'b0;
        end
      end
      if (P_CLR[i] != 0 && m_n[i] < d) begin
        m_mem[i][m_n[i]] = '0;
        m_kn[i][m_n[i]]  = 2'b11;
      end
      if (m_n[i] < 1000) m_n[i]++;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      bit          r;
      bit          known;
      logic [11:0] exp;
      r = mready(i);
      chk("ready", i, {11'b0, o_ry[i]}, {11'b0, r});
      if (P_SYNC[i] != 0) begin
        chk("rvalid", i, {11'b0, o_rv[i]}, {11'b0, m_rv[i]});
        if (m_rdk[i]) chk("rdata", i, o_rd[i], m_rd[i]);
      end else begin
        chk("rvalid", i, {11'b0, o_rv[i]}, {11'b0, r & re});
        known = 1'b1;
        if (!r) exp = m_rd[i];
        else if (int'(raddr) >= P_DEPTH[i]) exp = '0;
        else begin
          exp   = m_mem[i][raddr];
          known = (m_kn[i][raddr] == 2'b11);
        end
        if (known) chk("rdata", i, o_rd[i], exp);
      end
    end
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases before an edge.
  task automatic reset_pulse();
    #2 rstn = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_ready", i, {11'b0, o_ry[i]}, 12'h000);
      chk("rst_rvalid", i, {11'b0, o_rv[i]}, 12'h000);
      chk("rst_rdata", i, o_rd[i], 12'h000);
    end
    set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b0, 2'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 check_all();
    rstn = 1'b1;
  endtask

  logic [11:0] exp038;

  initial begin
    vectors = 0;
    errs    = 0;
    rstn    = 1'b0;
    set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 4; a++) begin
        m_mem[i][a] = '0;
        m_kn[i][a]  = 2'b00;
      end
    model_reset();

    @(negedge clk);
    #1 check_all();
    @(negedge clk);
    rstn = 1'b1;

    // Sweep: READY low for four cycles
    for (int k = 0; k < 4; k++) tick();
    #1 chk("ready_after_sweep", 0, {11'b0, o_ry[0]}, 12'h001);

    // Every address reads zero after the sweep
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b1, 2'(k));
      tick();
      #1 chk("sweep_zero", 0, o_rd[0], 12'h000);
      chk("sweep_rvalid", 0, {11'b0, o_rv[0]}, 12'h001);
    end

    // Masked write
    set_in(1'b1, 2'd2, 12'hFFF, 2'b11, 1'b0, 2'd0); tick();
    set_in(1'b1, 2'd2, 12'h000, 2'b01, 1'b0, 2'd0); tick();
    set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b1, 2'd2); tick();
    #1 chk("masked_write", 0, o_rd[0], 12'hFC0);

    // Read during write, same address: element 1 new, element 0 stored
    set_in(1'b1, 2'd1, 12'hABC, 2'b11, 1'b0, 2'd0); tick();
    set_in(1'b1, 2'd1, 12'h123, 2'b10, 1'b1, 2'd1); tick();
    exp038 = {wdata[11:6], 6'h3C};
    #1 chk("write_first", 0, o_rd[0], exp038);
    chk("write_first_rv", 0, {11'b0, o_rv[0]}, 12'h001);

    // Out of range on DEPTH=3
    set_in(1'b1, 2'd3, 12'hFFF, 2'b11, 1'b0, 2'd0); tick();
    set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b1, 2'd3); tick();
    #1 chk("oor_rdata", 1, o_rd[1], 12'h000);
    chk("oor_rvalid", 1, {11'b0, o_rv[1]}, 12'h001);

    // Combinational read sees the previous cycle's write
    set_in(1'b1, 2'd0, 12'h5A5, 2'b11, 1'b0, 2'd0); tick();
    set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b1, 2'd0);
    #1 chk("comb_rdata", 2, o_rd[2], 12'h5A5);
    chk("comb_rvalid", 2, {11'b0, o_rv[2]}, 12'h001);
    tick();

    // Reset on cycle 2 of the sweep, then writes during the restarted sweep
    reset_pulse();
    tick();
    tick();
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 2'(k), 12'hFFF, 2'b11, 1'b0, 2'd0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 2'd0, 12'h000, 2'b00, 1'b1, 2'(k));
      tick();
      #1 chk("resweep_zero", 0, o_rd[0], 12'h000);
    end

    // Random traffic with one reset while a read is in flight
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom), 2'($urandom), 12'($urandom), 2'($urandom),
             1'($urandom), 2'($urandom));
      if (n == 200) begin
        re = 1'b1;
        tick();
        reset_pulse();
      end
      tick();
    end

    #1 check_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire
